pe_systolic_os_drain: RTL
=========================

# pe_systolic_os_drain

Output-stationary systolic processing element. Adds four things the first-generation PE lacks: a configurable multiplier pipeline, a signed/unsigned operand mode, saturating accumulation with a sticky overflow flag, and a per-tile state machine with a shadow drain register. Instances tile into an R×C GEMM array. A and B operands flow east and south, and finished results shift out through a column-wise drain chain while the next tile is already accumulating.

## Interface

- DATA_W, 8: operand width.
- ACC_W, 32: accumulator width. Must be ≥ 2*DATA_W+1; elaboration error otherwise.
- MUL_PIPE, 1: product register stages. Legal values are 0, 1, 2.
- SATURATE, 1: 1 clamps on overflow; 0 wraps.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  synchronous tile restart. Flushes the mul pipeline, zeroes acc, clears ovf, sets state to IDLE.
- valid_in  in  1  operands valid.
- last_in  in  1  final k element of the tile. Qualified by valid_in.
- signed_mode  in  1  1 = signed operands and accumulation. Sampled with the operands.
- a_in  in  DATA_W  west operand.
- b_in  in  DATA_W  north operand.
- a_out  out  DATA_W  a_in, registered.
- b_out  out  DATA_W  b_in, registered.
- valid_out  out  1  valid_in, registered.
- last_out  out  1  last_in, registered.
- signed_out  out  1  signed_mode, registered.
- acc_out  out  ACC_W  live accumulator.
- done  out  1  state == DONE.
- ovf  out  1  sticky overflow for the current tile.
- drain_load  in  1  copy acc into the shadow register.
- drain_shift  in  1  shift the drain chain one position.
- drain_in  in  ACC_W  shadow value from the upstream (north) PE.
- drain_vin  in  1  upstream shadow valid.
- drain_out  out  ACC_W  shadow register.
- drain_vout  out  1  shadow valid.

## Operation

- Forwarding
  - a_out, b_out, valid_out, last_out and signed_out are registered every cycle, with 1-cycle latency.
  - Forwarding is unaffected by clear and by MUL_PIPE.
- Multiplier pipeline
  - Each stage carries {product, valid, last, signed}.
  - Stage 0 computes the product of the operands as registered into it: signed_mode=1 gives a signed product; 0 gives an unsigned product.
  - The product is sign- or zero-extended to ACC_W + 1 bits before adding.
  - A "pipeline output" (p_valid, p_last) emerges MUL_PIPE cycles after the operands are sampled. With MUL_PIPE=0 the product is combinational from a_in and b_in.
- Accumulate: sum = base + ext(product).
  - base = 0 if state ∈ {IDLE, DONE}; otherwise base = acc.
- Overflow
  - Signed mode: the result exceeds [−2^(ACC_W−1), 2^(ACC_W−1)−1].
  - Unsigned mode: the result exceeds 2^ACC_W−1.
  - On overflow, ovf is set.
  - SATURATE=1 clamps to the violated bound; SATURATE=0 keeps the low ACC_W bits.
  - ovf is cleared on clear, on rst, and at the first product of a new tile (entry from IDLE or DONE).
- FSM: IDLE, RUN, DONE.
  - IDLE → RUN on p_valid with !p_last.
  - IDLE → DONE on p_valid with p_last.
  - RUN → RUN on p_valid with !p_last.
  - RUN → DONE on p_valid with p_last.
  - RUN holds without p_valid.
  - DONE holds acc frozen until the next p_valid. That p_valid starts a new tile: acc = product, and the state goes to RUN, or to DONE if p_last. No clear is needed between tiles.
  - clear from any state → IDLE. In-flight products are dropped.
- Drain
  - drain_load: drain_out ← acc; drain_vout ← done.
  - Otherwise, drain_shift: drain_out ← drain_in; drain_vout ← drain_vin.
  - Otherwise drain_out and drain_vout hold.
  - drain_load has priority over drain_shift.
  - clear does not touch drain_out or drain_vout; only rst does.

## Timing

- Reset values: every output is 0. State = IDLE. Pipeline valids = 0.
- rst has priority over clear.
- An operand sampled at edge t updates acc, state, done and ovf at edge t+MUL_PIPE. The result is visible in the cycle that follows.
- MUL_PIPE=0: the operand accumulates at the same edge it is sampled.
- The drain chain has 1 cycle per hop. For an R-deep column, drain_load followed by R−1 drain_shift pulses presents every PE's result at the bottom PE's drain_out, nearest PE first.
- Simultaneous events
  - clear together with p_valid: clear wins.
  - drain_load in the same cycle as a final accumulation: the shadow captures the pre-update acc and drain_vout = the pre-update done.
  - valid_in=1 with last_in=1 on consecutive cycles: each is a 1-element tile, and DONE is entered each time.
- rst mid-tile: all state is lost and no partial result appears on drain_out.

## Test plan

1. Basic signed tile
   - Setup: MUL_PIPE=0, signed_mode=1.
   - Stimulus: a = {1, −2, 3, 4}, b = {5, 6, −7, 8}, last on the 4th element, on 4 consecutive edges.
   - Required: acc_out = 4; done rises the cycle after the 4th edge; ovf = 0.
2. Pipelined back-to-back tiles
   - Setup: MUL_PIPE=2.
   - Stimulus: tile A = {2·3, 4·5} with last, immediately followed by tile B = {1·1}.
   - Required: done shows acc = 26 for exactly 1 cycle, then acc = 1 and done stays high; each update lands 2 cycles after its operand.
3. Signed saturation
   - Setup: ACC_W=20, SATURATE=1, signed mode.
   - Stimulus: 33 × (127·127).
   - Required: acc = 516128 after 32 products; the 33rd clamps acc to 524287 and sets ovf.
   - Repeat with SATURATE=0: acc wraps to 532257 − 2^20 = −516319, and ovf = 1.
4. Unsigned saturation
   - Setup: ACC_W=20, SATURATE=1, signed_mode=0.
   - Stimulus: 17 × (255·255).
   - Required: acc clamps to 1048575; ovf = 1.
   - A following clear resets acc to 0 and ovf to 0.
5. Drain chain
   - Setup: 4-PE column finishing with results {10, 20, 30, 40}, PE0 at the top.
   - Stimulus: drain_load, then 3 drain_shift pulses.
   - Required: the bottom PE's drain_out reads 40, 30, 20, 10 on consecutive cycles with drain_vout = 1.
   - A new tile accumulating during the drain does not disturb the drained values.
6. Reset and clear priority
   - Stimulus: rst asserted mid-tile during RUN.
   - Required: the cycle after rst, all outputs = 0 and the state is IDLE.
   - Stimulus: clear coincident with p_valid.
   - Required: the product is dropped and acc = 0.

Source files
------------

// File: rtl/pe_systolic_os_drain.sv
// pe_systolic_os_drain: output-stationary systolic PE with pipelined multiplier, saturating accumulation and drain chain
module pe_systolic_os_drain #(
   parameter int DATA_W   = 8,
   parameter int ACC_W    = 32,
   parameter int MUL_PIPE = 1,
   parameter int SATURATE = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              valid_in,
   input  logic              last_in,
   input  logic              signed_mode,
   input  logic [DATA_W-1:0] a_in,
   input  logic [DATA_W-1:0] b_in,
   output logic [DATA_W-1:0] a_out,
   output logic [DATA_W-1:0] b_out,
   output logic              valid_out,
   output logic              last_out,
   output logic              signed_out,
   output logic [ACC_W-1:0]  acc_out,
   output logic              done,
   output logic              ovf,
   input  logic              drain_load,
   input  logic              drain_shift,
   input  logic [ACC_W-1:0]  drain_in,
   input  logic              drain_vin,
   output logic [ACC_W-1:0]  drain_out,
   output logic              drain_vout
);
   localparam int PW = 2*DATA_W+1;
   localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;

   if (ACC_W < 2*DATA_W+1 || MUL_PIPE < 0 || MUL_PIPE > 2) begin : g_bad
      $error("pe_systolic_os_drain: illegal parameter combination");
   end

   logic [1:0]          state;
   logic [2*DATA_W-1:0] sprod, uprod;
   logic [PW-1:0]       prod, p_prod;
   logic                p_valid, p_last, p_signed;
   logic [ACC_W:0]      base, p_ext, sum;
   logic                ov;
   logic [ACC_W-1:0]    nxt;

   always_comb begin
      sprod = $signed({{DATA_W{a_in[DATA_W-1]}}, a_in}) * $signed({{DATA_W{b_in[DATA_W-1]}}, b_in});
      uprod = {{DATA_W{1'b0}}, a_in} * {{DATA_W{1'b0}}, b_in};
      prod  = signed_mode ? {sprod[2*DATA_W-1], sprod} : {1'b0, uprod};
   end

   if (MUL_PIPE == 0) begin : g_comb
      assign p_prod   = prod;
      assign p_valid  = valid_in;
      assign p_last   = last_in;
      assign p_signed = signed_mode;
   end else begin : g_pipe
      logic [PW-1:0]       sp [MUL_PIPE];
      logic [MUL_PIPE-1:0] sv, sl, ss;
      always_ff @(posedge clk) begin
         sp[0] <= prod;
         for (int i = 1; i < MUL_PIPE; i++) sp[i] <= sp[i-1];
         sl <= MUL_PIPE'({sl, last_in});
         ss <= MUL_PIPE'({ss, signed_mode});
         sv <= rst || clear ? '0 : MUL_PIPE'({sv, valid_in});
      end
      assign p_prod   = sp[MUL_PIPE-1];
      assign p_valid  = sv[MUL_PIPE-1];
      assign p_last   = sl[MUL_PIPE-1];
      assign p_signed = ss[MUL_PIPE-1];
   end

   // one extra bit of headroom makes overflow a simple look at the top two sum bits
   always_comb begin
      p_ext = {{(ACC_W-2*DATA_W){p_prod[PW-1]}}, p_prod};
      base  = state == RUN ? {p_signed & acc_out[ACC_W-1], acc_out} : '0;
      sum   = base + p_ext;
      ov    = p_signed ? sum[ACC_W] ^ sum[ACC_W-1] : sum[ACC_W];
      nxt   = !ov || SATURATE == 0 ? sum[ACC_W-1:0] :
              !p_signed ? '1 :
              sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
   end

   always_ff @(posedge clk) begin
      a_out      <= rst ? '0 : a_in;
      b_out      <= rst ? '0 : b_in;
      valid_out  <= rst ? 1'b0 : valid_in;
      last_out   <= rst ? 1'b0 : last_in;
      signed_out <= rst ? 1'b0 : signed_mode;
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         state   <= IDLE;
         acc_out <= '0;
         ovf     <= 1'b0;
      end else if (p_valid) begin
         state   <= p_last ? DONE : RUN;
         acc_out <= nxt;
         ovf     <= ov | (state == RUN && ovf);
      end
   end

   always_ff @(posedge clk) begin
      drain_out  <= rst ? '0 : drain_load ? acc_out : drain_shift ? drain_in : drain_out;
      drain_vout <= rst ? 1'b0 : drain_load ? done : drain_shift ? drain_vin : drain_vout;
   end

   assign done = state == DONE;
endmodule
